// File: rtl/pipe_skid.sv
// Elastic pipeline stage with a two-entry (main + skid) buffer and valid/ready on both sides.
// Optional backpressure counter on stall_cnt_o is built when PIPE_SKID_STALL_CNT_EN is defined.
module pipe_skid #(
  parameter int unsigned     DW      = 32,
  parameter logic [DW-1:0]   RST_VAL = DW'(32'h0000_0013)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  input  logic          out_ready_i
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_main;
  logic [DW-1:0] r_skid;
  logic          r_skid_valid;
  logic          r_out_valid;
  logic          r_in_ready;

  logic          w_in_fire;
  logic          w_out_fire;

  assign w_in_fire  = in_valid_i & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready_i;

  // Handshake outputs come straight from flops; out_ready_i never reaches in_ready_o.
  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_main;

  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      r_state      <= ST_EMPTY;
      r_main       <= RST_VAL;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_state     <= ST_BUSY;
            r_main      <= in_data_i;
            r_out_valid <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= in_data_i;
          end else if (w_in_fire) begin
            r_state      <= ST_FULL;
            r_skid       <= in_data_i;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
          end else if (w_out_fire) begin
            // Going empty: park the NOP on the output so a bubble carries no stale word.
            r_state     <= ST_EMPTY;
            r_main      <= RST_VAL;
            r_out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            r_state      <= ST_BUSY;
            r_main       <= r_skid;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_EMPTY;
          r_main       <= RST_VAL;
          r_skid_valid <= 1'b0;
          r_out_valid  <= 1'b0;
          r_in_ready   <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Survives flush on purpose; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= 16'h0000;
    end else if (r_out_valid && !out_ready_i && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: doc/pipe_skid.md
# pipe_skid

Elastic pipeline stage with a two-entry skid buffer and a valid/ready handshake on both sides. It is the consuming end of an upstream stage (e.g. IF→ID) and forwards each word downstream, absorbing one cycle of backpressure without combinational ready paths. Reset and flush force the stage empty and drive the configured reset value (a NOP) onto the output, so a bubble never carries stale data.

## Interface
- DW, 32, data width
- RST_VAL, 32'h0000_0013, output value while empty / after reset or flush (RV32I `addi x0,x0,0`)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- flush_i  in  1  discard all held entries, synchronous
- in_valid_i  in  1  upstream word valid
- in_data_i  in  DW  upstream word
- in_ready_o  out  1  stage can accept; registered
- out_valid_o  out  1  downstream word valid; registered
- out_data_o  out  DW  downstream word; registered
- out_ready_i  in  1  downstream accepts
- stall_cnt_o  out  16  backpressure cycle count (only with PIPE_SKID_STALL_CNT_EN)

## Operation
- Storage: main register (drives out_data_o) and skid register, each with a valid bit.
- in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- in_ready_o = ~skid_valid, registered. No combinational path from out_ready_i to in_ready_o.
- States: EMPTY (no entry), BUSY (main only), FULL (main + skid).
- EMPTY: in_fire → BUSY, main ← in_data_i.
- BUSY: in_fire & out_fire → BUSY, main ← in_data_i. in_fire & !out_fire → FULL, skid ← in_data_i. !in_fire & out_fire → EMPTY. Otherwise hold.
- FULL: in_ready_o = 0. out_fire → BUSY, main ← skid. Otherwise hold.
- On the transition into EMPTY, main ← RST_VAL, so out_data_o == RST_VAL whenever out_valid_o == 0.
- Order is strictly FIFO. No word is duplicated or dropped except on flush/reset.
- in_valid_i while in_ready_o == 0 has no effect. The producer holds the word.

## Timing
- Reset (rst == 0 at posedge): state EMPTY, out_valid_o = 0, out_data_o = RST_VAL, in_ready_o = 1, skid cleared, stall_cnt_o = 0.
- Latency: a word accepted at edge N is on out_data_o with out_valid_o = 1 after edge N. One-cycle latency.
- Throughput: one word per cycle while out_ready_i is held high.
- Backpressure: after one cycle of out_ready_i = 0 with a concurrent in_fire, the stage is FULL. in_ready_o drops after that edge.
- Flush: same effect as reset, except stall_cnt_o is preserved. Flush wins over in_fire and out_fire in the same cycle.
  - An upstream word handshaking in the flush cycle is squashed.
  - Downstream must ignore out_fire in the flush cycle.
- Reset has priority over flush.
- out_valid_o stays 1 and out_data_o stays stable until out_fire (no retraction).

## Configuration
- PIPE_SKID_STALL_CNT_EN defined:
  - stall_cnt_o is present.
  - It increments each cycle with out_valid_o & !out_ready_i and saturates at 16'hFFFF.
  - It is cleared only by reset.
- PIPE_SKID_STALL_CNT_EN undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset then idle: out_valid_o = 0, out_data_o = 32'h13, in_ready_o = 1 for ≥ 3 cycles.
- Streaming: push 0x100..0x10F back-to-back with out_ready_i = 1 → same 16 words out in order, 1-cycle latency, no gaps, in_ready_o stays 1.
- Backpressure:
  - Stimulus: push 0xA, 0xB with out_ready_i = 0.
  - Required response: FULL; in_ready_o = 0; out_data_o = 0xA stable; 0xC is held upstream.
  - Then raise out_ready_i: 0xA, 0xB, 0xC are delivered in order.
- Flush while FULL with concurrent in_fire: the next cycle shows out_valid_o = 0, out_data_o = 32'h13, in_ready_o = 1. No flushed word ever appears.
- Drain to empty: single word 0x55 consumed with no new input → out_valid_o = 0 and out_data_o = 32'h13 on the next cycle.
- With PIPE_SKID_STALL_CNT_EN:
  - Hold a valid word for 5 cycles with out_ready_i = 0 → stall_cnt_o = 5.
  - Flush → still 5.
  - Reset → 0.
